// File: rtl/sr_lsu.sv
// ---------------------------------------------------------------------------
// sr_lsu -- single-request load/store unit
//
// Accepts one core access at a time, checks it for alignment and size
// legality, drives a simple req/ack memory port with lane-positioned data,
// and returns an extended load result or a one-cycle fault pulse.
//
// Parameters
//   XLEN      data path width, 32 or 64
//   ADDR_W    byte address width
//   MAX_WAIT  mem_req cycles without mem_ack before a timeout fault
//
// Ports
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   lsu_valid / lsu_ready        core request handshake (ready only when idle)
//   lsu_we, lsu_size, lsu_sign   store flag, access size (1/2/4/8 bytes), sign-extend
//   lsu_addr, lsu_wdata          byte address, right-aligned store data
//   lsu_rdata                    extended load result (held between loads)
//   lsu_done, lsu_fault          one-cycle completion / fault pulses
//   mem_req, mem_we, mem_be      memory request, write enable, byte-lane enables
//   mem_addr, mem_wdata          lane-aligned address, replicated store data
//   mem_ack, mem_rdata           memory completion and read data
// ---------------------------------------------------------------------------
module sr_lsu #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic                lsu_we,
    input  logic [1:0]          lsu_size,
    input  logic                lsu_sign,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [XLEN-1:0]     lsu_wdata,
    output logic [XLEN-1:0]     lsu_rdata,
    output logic                lsu_done,
    output logic                lsu_fault,
    output logic                mem_req,
    output logic                mem_we,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        FAULT
    } state_t;

    state_t state;
    state_t state_next;

    logic              accept;
    logic              size_illegal;
    logic              misaligned;
    logic              req_bad;
    logic              timeout;
    logic [OFF_W-1:0]  in_off;
    logic [NB-1:0]     be_base;
    logic [NB-1:0]     be_next;
    logic [XLEN-1:0]   wdata_next;
    logic [XLEN-1:0]   load_value;
    logic [CNT_W-1:0]  wait_cnt;

    // Fields needed later to extract the load result from mem_rdata.
    logic [1:0]        req_size;
    logic              req_sign;
    logic [OFF_W-1:0]  req_off;

    // Copies the low 2^size bytes of the store data into every lane, so the
    // memory picks the right bytes whatever lane the access lands on.  A
    // full-width access maps each lane onto itself and passes data unchanged.
    function automatic logic [XLEN-1:0] replicate_lanes(
        input logic [XLEN-1:0] data,
        input logic [1:0]      size
    );
        logic [XLEN-1:0] result;
        int              mask;
        result = '0;
        mask   = (1 << size) - 1;
        for (int i = 0; i < NB; i++) begin
            result[i*8 +: 8] = data[(i & mask)*8 +: 8];
        end
        return result;
    endfunction

    // Brings the addressed bytes down to bit 0, keeps 2^size bytes and
    // fills the rest with the top kept bit (signed) or zeros (unsigned).
    function automatic logic [XLEN-1:0] extract_load(
        input logic [XLEN-1:0]  data,
        input logic [OFF_W-1:0] off,
        input logic [1:0]       size,
        input logic             sign
    );
        logic [XLEN-1:0] shifted;
        logic [XLEN-1:0] result;
        logic            fill;
        int              nbits;
        shifted = data >> {off, 3'b000};
        nbits   = 8 << size;
        if (nbits > XLEN) begin
            nbits = XLEN;
        end
        fill   = sign & shifted[nbits-1];
        result = '0;
        for (int i = 0; i < XLEN; i++) begin
            result[i] = (i < nbits) ? shifted[i] : fill;
        end
        return result;
    endfunction

    // Request decode: legality is judged on the raw inputs in the accept
    // cycle, so an illegal access never reaches the memory port.
    always_comb begin
        in_off       = lsu_addr[OFF_W-1:0];
        accept       = lsu_valid && (state == IDLE);
        size_illegal = (lsu_size == 2'd3) && (XLEN == 32);
        misaligned   = 1'b0;
        case (lsu_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = lsu_addr[0];
            2'd2:    misaligned = |lsu_addr[1:0];
            default: misaligned = |lsu_addr[2:0];
        endcase
        req_bad = size_illegal || misaligned;
    end

    // Byte-lane enables: 2^size contiguous lanes starting at the lane offset.
    always_comb begin
        be_base = '0;
        case (lsu_size)
            2'd0:    be_base = NB'(1);
            2'd1:    be_base = NB'(3);
            2'd2:    be_base = NB'(15);
            default: be_base = '1;
        endcase
        be_next    = be_base << in_off;
        wdata_next = replicate_lanes(lsu_wdata, lsu_size);
    end

    // The wait counter holds the number of ACCESS cycles already spent
    // without an ack, so the current cycle is the MAX_WAIT-th one when it
    // equals MAX_WAIT-1.  An ack in that same cycle still takes priority.
    always_comb begin
        timeout    = (wait_cnt == CNT_W'(MAX_WAIT - 1));
        load_value = extract_load(mem_rdata, req_off, req_size, req_sign);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.  mem_ack is only looked at in ACCESS, so a late
    // or stray ack in any other state has no effect.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = req_bad ? FAULT : ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_next = RESP;
                end else if (timeout) begin
                    state_next = FAULT;
                end
            end
            RESP:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: every handshake signal is a pure decode of the state,
    // which keeps done and fault mutually exclusive by construction.
    always_comb begin
        lsu_ready = 1'b0;
        mem_req   = 1'b0;
        lsu_done  = 1'b0;
        lsu_fault = 1'b0;
        case (state)
            IDLE:    lsu_ready = 1'b1;
            ACCESS:  mem_req   = 1'b1;
            RESP:    lsu_done  = 1'b1;
            FAULT:   lsu_fault = 1'b1;
            default: lsu_ready = 1'b0;
        endcase
    end

    // Memory-side request fields are captured once at accept and then held,
    // which keeps them stable for the whole ACCESS period.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req_size  <= '0;
            req_sign  <= 1'b0;
            req_off   <= '0;
        end else if (accept && !req_bad) begin
            mem_we    <= lsu_we;
            mem_be    <= be_next;
            mem_addr  <= {lsu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_wdata <= wdata_next;
            req_size  <= lsu_size;
            req_sign  <= lsu_sign;
            req_off   <= in_off;
        end
    end

    // Wait counter: advances on each un-acked ACCESS cycle and clears
    // whenever the access ends or the FSM is elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !mem_ack && !timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Load result: only an acked load updates it; stores, faults and
    // timeouts leave the previous value visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_rdata <= '0;
        end else if ((state == ACCESS) && mem_ack && !mem_we) begin
            lsu_rdata <= load_value;
        end
    end

endmodule

// File: tb/tb_sr_lsu.sv
// ---------------------------------------------------------------------------
// tb_sr_lsu -- scoreboard bench for sr_lsu (XLEN=32, MAX_WAIT=4)
//
// Directed vectors carry hand-computed expectations.  Issuing a vector
// pushes the expected memory request and the expected core response into
// queues; two monitors pop and compare whenever the DUT raises mem_req or
// pulses lsu_done / lsu_fault.  The driver also checks cycle timing.
// ---------------------------------------------------------------------------
module tb_sr_lsu;

    localparam int XLEN     = 32;
    localparam int ADDR_W   = 32;
    localparam int MAX_WAIT = 4;

    typedef struct packed {
        logic        fault;
        logic [31:0] rdata;
    } resp_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    logic              clk;
    logic              rst;
    logic              lsu_valid;
    logic              lsu_ready;
    logic              lsu_we;
    logic [1:0]        lsu_size;
    logic              lsu_sign;
    logic [ADDR_W-1:0] lsu_addr;
    logic [XLEN-1:0]   lsu_wdata;
    logic [XLEN-1:0]   lsu_rdata;
    logic              lsu_done;
    logic              lsu_fault;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    int    checks;
    int    errors;
    resp_t resp_q[$];
    mreq_t mreq_q[$];

    sr_lsu #(
        .XLEN     (XLEN),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_we    (lsu_we),
        .lsu_size  (lsu_size),
        .lsu_sign  (lsu_sign),
        .lsu_addr  (lsu_addr),
        .lsu_wdata (lsu_wdata),
        .lsu_rdata (lsu_rdata),
        .lsu_done  (lsu_done),
        .lsu_fault (lsu_fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Memory-side monitor: pops an expectation on each new request and
    // checks the request fields on every cycle mem_req stays high.
    initial begin
        logic  prev_req;
        logic  cur_valid;
        mreq_t cur;
        prev_req  = 1'b0;
        cur_valid = 1'b0;
        cur       = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (!prev_req) begin
                    if (mreq_q.size() == 0) begin
                        checkOutput("mem_req_expected", 32'(mreq_q.size()), 32'd1);
                        cur_valid = 1'b0;
                    end else begin
                        cur       = mreq_q.pop_front();
                        cur_valid = 1'b1;
                    end
                end
                if (cur_valid) begin
                    checkOutput("mem_we",    32'(mem_we), 32'(cur.we));
                    checkOutput("mem_be",    32'(mem_be), 32'(cur.be));
                    checkOutput("mem_addr",  mem_addr,    cur.addr);
                    checkOutput("mem_wdata", mem_wdata,   cur.wdata);
                end
            end
            prev_req = (mem_req === 1'b1);
        end
    end

    // Core-side monitor: every done or fault pulse must match the next
    // queued response, and the two pulses must never coincide.
    initial begin
        resp_t exp_r;
        forever begin
            @(negedge clk);
            if (lsu_done === 1'b1 || lsu_fault === 1'b1) begin
                checkOutput("done_fault_exclusive", 32'(lsu_done & lsu_fault), 32'd0);
                if (resp_q.size() == 0) begin
                    checkOutput("response_expected", 32'(resp_q.size()), 32'd1);
                end else begin
                    exp_r = resp_q.pop_front();
                    checkOutput("resp_kind",  32'(lsu_fault), 32'(exp_r.fault));
                    checkOutput("resp_rdata", lsu_rdata,      exp_r.rdata);
                end
            end
        end
    end

    // ack_delay: -2 = rejected at accept, -1 = never ack, n>=0 = ack on
    // the (n+1)-th mem_req cycle.
    task automatic applyStimulus(
        input string       name,
        input logic        we,
        input logic [1:0]  size,
        input logic        sign,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input int          ack_delay,
        input logic [31:0] rd,
        input logic        exp_fault,
        input logic [31:0] exp_rdata,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_maddr,
        input logic [31:0] exp_mwdata
    );
        int req_cycles;
        bit ended;
        resp_q.push_back('{exp_fault, exp_rdata});
        if (ack_delay != -2) begin
            mreq_q.push_back('{we, exp_be, exp_maddr, exp_mwdata});
        end
        @(negedge clk);
        checkOutput({name, "_ready_idle"}, 32'(lsu_ready), 32'd1);
        lsu_valid = 1'b1;
        lsu_we    = we;
        lsu_size  = size;
        lsu_sign  = sign;
        lsu_addr  = addr;
        lsu_wdata = wdata;
        @(posedge clk);
        #1;
        lsu_valid = 1'b0;
        if (ack_delay == -2) begin
            @(negedge clk);
            checkOutput({name, "_fault_pulse"}, 32'(lsu_fault), 32'd1);
            checkOutput({name, "_no_req"},      32'(mem_req),   32'd0);
            @(negedge clk);
            checkOutput({name, "_ready_after"}, 32'(lsu_ready), 32'd1);
            checkOutput({name, "_fault_clear"}, 32'(lsu_fault), 32'd0);
        end else begin
            req_cycles = 0;
            ended      = 1'b0;
            for (int cyc = 0; cyc < 20 && !ended; cyc++) begin
                @(negedge clk);
                if (mem_req !== 1'b1) begin
                    ended = 1'b1;
                    if (ack_delay < 0) begin
                        checkOutput({name, "_req_cycles"},  32'(req_cycles), 32'(MAX_WAIT));
                        checkOutput({name, "_timeout_flt"}, 32'(lsu_fault),  32'd1);
                    end else begin
                        checkOutput({name, "_req_held"}, 32'(mem_req), 32'd1);
                    end
                end else begin
                    req_cycles++;
                    if (req_cycles - 1 == ack_delay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rd;
                        @(posedge clk);
                        #1;
                        mem_ack   = 1'b0;
                        mem_rdata = '0;
                        @(negedge clk);
                        checkOutput({name, "_done_after_ack"}, 32'(lsu_done), 32'd1);
                        checkOutput({name, "_req_dropped"},    32'(mem_req),  32'd0);
                        ended = 1'b1;
                    end
                end
            end
            if (!ended) begin
                checkOutput({name, "_wait_bound"}, 32'(mem_req), 32'd0);
            end
            @(negedge clk);
            checkOutput({name, "_ready_after"}, 32'(lsu_ready), 32'd1);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        lsu_valid = 1'b0;
        lsu_we    = 1'b0;
        lsu_size  = 2'd0;
        lsu_sign  = 1'b0;
        lsu_addr  = '0;
        lsu_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready",     32'(lsu_ready), 32'd1);
        checkOutput("rst_done",      32'(lsu_done),  32'd0);
        checkOutput("rst_fault",     32'(lsu_fault), 32'd0);
        checkOutput("rst_mem_req",   32'(mem_req),   32'd0);
        checkOutput("rst_mem_we",    32'(mem_we),    32'd0);
        checkOutput("rst_mem_be",    32'(mem_be),    32'd0);
        checkOutput("rst_mem_addr",  mem_addr,       32'd0);
        checkOutput("rst_mem_wdata", mem_wdata,      32'd0);
        checkOutput("rst_rdata",     lsu_rdata,      32'd0);
        rst = 1'b0;

        //             name     we    size  sign  addr          wdata         ack  mem_rdata     flt   exp_rdata     be       maddr         mwdata
        applyStimulus("sw",     1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF, 2,  32'h0,        1'b0, 32'h00000000, 4'b1111, 32'h104, 32'hDEADBEEF);
        applyStimulus("lb_s",   1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        0,  32'h80123456, 1'b0, 32'hFFFFFF80, 4'b1000, 32'h100, 32'h0);
        applyStimulus("lb_u",   1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        1,  32'h80123456, 1'b0, 32'h00000080, 4'b1000, 32'h100, 32'h0);
        applyStimulus("sh",     1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 0,  32'h0,        1'b0, 32'h00000080, 4'b1100, 32'h100, 32'hABCDABCD);
        applyStimulus("lw_mis", 1'b0, 2'd2, 1'b0, 32'h101, 32'h0,        -2, 32'h0,        1'b1, 32'h00000080, 4'b0000, 32'h0,   32'h0);
        applyStimulus("lh_s",   1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        0,  32'h80123456, 1'b0, 32'hFFFF8012, 4'b1100, 32'h100, 32'h0);
        applyStimulus("lh_u",   1'b0, 2'd1, 1'b0, 32'h100, 32'h0,        0,  32'h1234F00D, 1'b0, 32'h0000F00D, 4'b0011, 32'h100, 32'h0);
        applyStimulus("lw_ack4",1'b0, 2'd2, 1'b0, 32'h108, 32'h0,        3,  32'hCAFEBABE, 1'b0, 32'hCAFEBABE, 4'b1111, 32'h108, 32'h0);
        applyStimulus("lw_tmo", 1'b0, 2'd2, 1'b0, 32'h10C, 32'h0,        -1, 32'h0,        1'b1, 32'hCAFEBABE, 4'b1111, 32'h10C, 32'h0);
        applyStimulus("ld_ill", 1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        -2, 32'h0,        1'b1, 32'hCAFEBABE, 4'b0000, 32'h0,   32'h0);
        applyStimulus("sb",     1'b1, 2'd0, 1'b0, 32'h101, 32'h0000005A, 1,  32'h0,        1'b0, 32'hCAFEBABE, 4'b0010, 32'h100, 32'h5A5A5A5A);
        applyStimulus("lb_pos", 1'b0, 2'd0, 1'b1, 32'h102, 32'h0,        0,  32'h007F0000, 1'b0, 32'h0000007F, 4'b0100, 32'h100, 32'h0);

        // Reset during ACCESS, then a late ack: must vanish without a pulse.
        mreq_q.push_back('{1'b0, 4'b1111, 32'h300, 32'h0});
        @(negedge clk);
        lsu_valid = 1'b1;
        lsu_we    = 1'b0;
        lsu_size  = 2'd2;
        lsu_sign  = 1'b0;
        lsu_addr  = 32'h300;
        lsu_wdata = 32'h0;
        @(posedge clk);
        #1;
        lsu_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_req_up", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_req",   32'(mem_req),   32'd0);
        checkOutput("rstmid_ready", 32'(lsu_ready), 32'd1);
        checkOutput("rstmid_done",  32'(lsu_done),  32'd0);
        checkOutput("rstmid_fault", 32'(lsu_fault), 32'd0);
        checkOutput("rstmid_rdata", lsu_rdata,      32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        checkOutput("late_ack_done",  32'(lsu_done),  32'd0);
        checkOutput("late_ack_fault", 32'(lsu_fault), 32'd0);
        checkOutput("late_ack_ready", 32'(lsu_ready), 32'd1);
        checkOutput("late_ack_rdata", lsu_rdata,      32'd0);

        // Normal operation resumes after the abandoned access.
        applyStimulus("lw_post",1'b0, 2'd2, 1'b0, 32'h200, 32'h0,        0,  32'h0F0F0F0F, 1'b0, 32'h0F0F0F0F, 4'b1111, 32'h200, 32'h0);

        repeat (3) @(negedge clk);
        checkOutput("resp_q_drained", 32'(resp_q.size()), 32'd0);
        checkOutput("mreq_q_drained", 32'(mreq_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
